// File: rtl/core_cp15_responder_pkg.sv
// CP15 shared definitions: register numbers, FSM states, SCTLR bit positions.
// Optional cycle counter (c15,c12,op2=1) is enabled by CORE_CP15_CYCLE_COUNTER_EN.
package core_cp15_responder_pkg;

    typedef struct packed {
        logic [3:0] crn;
        logic [3:0] crm;
        logic [2:0] op1;
        logic [2:0] op2;
        logic       load;
    } coproc_decode;

    localparam logic [3:0] CP15_ID    = 4'd0;
    localparam logic [3:0] CP15_CTRL  = 4'd1;
    localparam logic [3:0] CP15_TTBR  = 4'd2;
    localparam logic [3:0] CP15_DACR  = 4'd3;
    localparam logic [3:0] CP15_FSR   = 4'd5;
    localparam logic [3:0] CP15_FAR   = 4'd6;
    localparam logic [3:0] CP15_CACHE = 4'd7;
    localparam logic [3:0] CP15_TLB   = 4'd8;
    localparam logic [3:0] CP15_CNT   = 4'd15;
    localparam logic [3:0] CP15_CNT_M = 4'd12;

    localparam int SCTLR_M = 0;
    localparam int SCTLR_C = 2;

    typedef enum logic [1:0] {
        IDLE,
        RESP,
        FLUSH
    } cp15_state;

    typedef enum logic [3:0] {
        SEL_NONE,
        SEL_ID,
        SEL_CTRL,
        SEL_TTBR,
        SEL_DACR,
        SEL_FSR,
        SEL_FAR,
        SEL_CNT
    } cp15_sel;

endpackage

// File: rtl/core_cp15_responder_map.sv
// Combinational decode of a CP15 transfer into register select and flags.
// CORE_CP15_CYCLE_COUNTER_EN adds the c15 cycle counter decode.
module core_cp15_map
    import core_cp15_responder_pkg::*;
(
    input  coproc_decode decode,
    output cp15_sel      sel,
    output logic         undefined,
    output logic         maint
);

    logic reg0;
    assign reg0 = (decode.crm == 4'd0) && (decode.op2 == 3'd0);

    always_comb begin
        sel       = SEL_NONE;
        undefined = 1'b0;
        maint     = 1'b0;
        if (decode.op1 != 3'd0) begin
            undefined = 1'b1;
        end else if (decode.crn == CP15_CACHE || decode.crn == CP15_TLB) begin
            // maintenance ops are write-only
            if (decode.load) undefined = 1'b1;
            else             maint     = 1'b1;
        end else begin
            case (decode.crn)
                CP15_ID: begin
                    if (reg0 && decode.load) sel = SEL_ID;
                    else                     undefined = 1'b1;
                end
                CP15_CTRL: if (reg0) sel = SEL_CTRL; else undefined = 1'b1;
                CP15_TTBR: if (reg0) sel = SEL_TTBR; else undefined = 1'b1;
                CP15_DACR: if (reg0) sel = SEL_DACR; else undefined = 1'b1;
                CP15_FSR:  if (reg0) sel = SEL_FSR;  else undefined = 1'b1;
                CP15_FAR:  if (reg0) sel = SEL_FAR;  else undefined = 1'b1;
`ifdef CORE_CP15_CYCLE_COUNTER_EN
                CP15_CNT: begin
                    if (decode.crm == CP15_CNT_M && decode.op2 == 3'd1)
                        sel = SEL_CNT;
                    else
                        undefined = 1'b1;
                end
`endif
                default: undefined = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/core_cp15_responder.sv
// CP15 system-control responder: register file, maintenance handshake, fault record.
// CORE_CP15_CYCLE_COUNTER_EN adds a free-running RW cycle counter at c15,c12,op2=1.
module core_cp15_responder
    import core_cp15_responder_pkg::*;
#(
    parameter logic [31:0] ID_CODE = 32'h4107_B360
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  coproc_decode decode,
    input  logic [31:0]  write,
    output logic         ready,
    output logic [31:0]  read,
    output logic         undefined,
    output logic         busy,
    output logic         mmu_enable,
    output logic         cache_enable,
    output logic [17:0]  ttbr,
    output logic [31:0]  dacr,
    input  logic         fault,
    input  logic [3:0]   fault_status,
    input  logic [3:0]   fault_domain,
    input  logic [31:0]  fault_addr,
    output logic         flush_req,
    input  logic         flush_ack
);

    cp15_state   state;
    cp15_sel     sel;
    logic        undef;
    logic        maint;
    logic        accept;
    logic        commit;
    logic [7:0]  fsr;
    logic [31:0] far_q;
    logic [31:0] rdata;
`ifdef CORE_CP15_CYCLE_COUNTER_EN
    logic [31:0] cycle_cnt;
`endif

    core_cp15_map u_map (
        .decode    (decode),
        .sel       (sel),
        .undefined (undef),
        .maint     (maint)
    );

    assign busy   = (state != IDLE);
    assign accept = (state == IDLE) && start;
    assign commit = accept && !decode.load && !undef;

    always_comb begin
        rdata = 32'h0;
        case (sel)
            SEL_ID:   rdata = ID_CODE;
            SEL_CTRL: begin
                rdata[SCTLR_M] = mmu_enable;
                rdata[SCTLR_C] = cache_enable;
            end
            SEL_TTBR: rdata = {ttbr, 14'h0};
            SEL_DACR: rdata = dacr;
            SEL_FSR:  rdata = {24'h0, fsr};
            SEL_FAR:  rdata = far_q;
`ifdef CORE_CP15_CYCLE_COUNTER_EN
            SEL_CNT:  rdata = cycle_cnt;
`endif
            default:  rdata = 32'h0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ready     <= 1'b0;
            read      <= 32'h0;
            undefined <= 1'b0;
            flush_req <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && maint) begin
                        state     <= FLUSH;
                        flush_req <= 1'b1;
                    end else if (start) begin
                        state     <= RESP;
                        ready     <= 1'b1;
                        read      <= (decode.load && !undef) ? rdata : 32'h0;
                        undefined <= undef;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    ready     <= 1'b0;
                    read      <= 32'h0;
                    undefined <= 1'b0;
                end
                FLUSH: begin
                    if (flush_ack) begin
                        state     <= RESP;
                        flush_req <= 1'b0;
                        ready     <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mmu_enable   <= 1'b0;
            cache_enable <= 1'b0;
            ttbr         <= 18'h0;
            dacr         <= 32'h0;
            fsr          <= 8'h0;
            far_q        <= 32'h0;
        end else begin
            if (commit) begin
                case (sel)
                    SEL_CTRL: begin
                        mmu_enable   <= write[SCTLR_M];
                        cache_enable <= write[SCTLR_C];
                    end
                    SEL_TTBR: ttbr  <= write[31:14];
                    SEL_DACR: dacr  <= write;
                    SEL_FSR:  fsr   <= write[7:0];
                    SEL_FAR:  far_q <= write;
                    default:  ;
                endcase
            end
            // abort record overrides a same-edge software write
            if (fault) begin
                fsr   <= {fault_domain, fault_status};
                far_q <= fault_addr;
            end
        end
    end

`ifdef CORE_CP15_CYCLE_COUNTER_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cycle_cnt <= 32'h0;
        else if (commit && sel == SEL_CNT)
            cycle_cnt <= write;
        else
            cycle_cnt <= cycle_cnt + 32'd1;
    end
`endif

endmodule
